mem_burst_ctrl: RTL and testbench

- Initiator-side controller for the block memory.
- Accepts word-granular read/write burst requests from a SIMD core and splits each into BLOCK_SIZE-word memory accesses on the memory's write and read ports.
- Returns read data as BLOCK_SIZE-wide beats over a valid/ready channel.
- Sits between the core's load/store path and the memory instance.

---
 rtl/mem_burst_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_ctrl.sv
// Burst controller between a SIMD core's load/store path and the block memory.
// Splits word-granular read/write bursts into BLOCK_SIZE-word memory beats.
module mem_burst_ctrl #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned BLOCK_SIZE = 5,
  parameter int unsigned ADDR_SIZE  = 24,
  parameter int unsigned LEN_W      = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_req_valid,
  output logic                               o_req_ready,
  input  logic                               i_req_we,
  input  logic [ADDR_SIZE-1:0]               i_req_addr,
  input  logic [LEN_W-1:0]                   i_req_len,
  input  logic                               i_wdata_valid,
  output logic                               o_wdata_ready,
  input  logic [SIZE*BLOCK_SIZE-1:0]         i_wdata,
  output logic                               o_rdata_valid,
  input  logic                               i_rdata_ready,
  output logic [SIZE*BLOCK_SIZE-1:0]         o_rdata,
  output logic [$clog2(BLOCK_SIZE):0]        o_rdata_cnt,
  output logic                               o_rdata_last,
  output logic                               o_done,
  output logic [ADDR_SIZE-1:0]               o_mem_addr_w,
  output logic [SIZE*BLOCK_SIZE-1:0]         o_mem_data_w,
  output logic [$clog2(BLOCK_SIZE):0]        o_mem_wr_size,
  output logic                               o_mem_wr_en,
  output logic [ADDR_SIZE-1:0]               o_mem_addr_r,
  input  logic [SIZE*BLOCK_SIZE-1:0]         i_mem_data
);

  localparam int unsigned CNT_W  = $clog2(BLOCK_SIZE) + 1;
  localparam int unsigned BEAT_W = SIZE * BLOCK_SIZE;

  typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

  state_t               state, state_d;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [LEN_W-1:0]     remaining;
  logic [CNT_W-1:0]     beat_c;
  logic                 final_c;
  logic                 req_fire, wr_fire, rd_capture, rd_consume;
  logic [BEAT_W-1:0]    rdata_masked;

  // Words in the current beat and whether it closes the burst
  always_comb begin
    beat_c  = (remaining < LEN_W'(BLOCK_SIZE)) ? CNT_W'(remaining) : CNT_W'(BLOCK_SIZE);
    final_c = (remaining <= LEN_W'(BLOCK_SIZE));
  end

  // Zero the slots past the beat size so partial beats carry no stale words
  always_comb begin
    rdata_masked = i_mem_data;
    for (int unsigned k = 0; k < BLOCK_SIZE; k++) begin
      if (k >= 32'(beat_c)) rdata_masked[(BLOCK_SIZE-k)*SIZE-1 -: SIZE] = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    req_fire   = 1'b0;
    wr_fire    = 1'b0;
    rd_capture = 1'b0;
    rd_consume = 1'b0;
    case (state)
      IDLE: begin
        req_fire = i_req_valid && o_req_ready;
        if (req_fire) begin
          if (i_req_len == '0) state_d = FIN;
          else if (i_req_we)   state_d = WR;
          else                 state_d = RD;
        end
      end
      WR: begin
        wr_fire = i_wdata_valid && o_wdata_ready;
        if (wr_fire && final_c) state_d = FIN;
      end
      RD: begin
        rd_consume = o_rdata_valid && i_rdata_ready;
        rd_capture = (!o_rdata_valid || i_rdata_ready) && (remaining != '0);
        if (rd_consume && o_rdata_last) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and burst bookkeeping; reset lands in IDLE, which accepts requests
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_req_ready   <= 1'b1;
      o_wdata_ready <= 1'b0;
      o_done        <= 1'b0;
      o_mem_wr_en   <= 1'b0;
      o_mem_addr_w  <= '0;
      o_mem_data_w  <= '0;
      o_mem_wr_size <= '0;
      o_mem_addr_r  <= '0;
      o_rdata_valid <= 1'b0;
      o_rdata       <= '0;
      o_rdata_cnt   <= '0;
      o_rdata_last  <= 1'b0;
      addr_q        <= '0;
      remaining     <= '0;
    end else begin
      o_req_ready   <= (state_d == IDLE);
      o_wdata_ready <= (state_d == WR);
      o_done        <= (state_d == FIN);
      o_mem_wr_en   <= wr_fire;

      if (req_fire) begin
        addr_q    <= i_req_addr;
        remaining <= i_req_len;
        if (!i_req_we && (i_req_len != '0)) o_mem_addr_r <= i_req_addr;
      end

      if (wr_fire) begin
        o_mem_addr_w  <= addr_q;
        o_mem_data_w  <= i_wdata;
        o_mem_wr_size <= beat_c;
        addr_q        <= addr_q + ADDR_SIZE'(beat_c);
        remaining     <= remaining - LEN_W'(beat_c);
      end

      if (rd_capture) begin
        o_rdata       <= rdata_masked;
        o_rdata_cnt   <= beat_c;
        o_rdata_last  <= final_c;
        o_rdata_valid <= 1'b1;
        o_mem_addr_r  <= o_mem_addr_r + ADDR_SIZE'(beat_c);
        remaining     <= remaining - LEN_W'(beat_c);
      end else if (rd_consume) begin
        o_rdata_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Directed bench for mem_burst_ctrl with a small word memory behind the ports.
module tb_mem_burst_ctrl;

  logic         clk;
  logic         rst;
  logic         req_valid, req_ready, req_we;
  logic [23:0]  req_addr;
  logic [15:0]  req_len;
  logic         wdata_valid, wdata_ready;
  logic [159:0] wdata;
  logic         rdata_valid, rdata_ready;
  logic [159:0] rdata;
  logic [3:0]   rdata_cnt;
  logic         rdata_last, done;
  logic [23:0]  mem_addr_w, mem_addr_r;
  logic [159:0] mem_data_w, mem_data;
  logic [3:0]   mem_wr_size;
  logic         mem_wr_en;
  logic         mem_init;

  logic [31:0]  mem [256];
  logic [31:0]  wd  [7];
  logic [31:0]  xd  [5];
  logic [31:0]  junk;
  int           checks;
  int           failures;

  mem_burst_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_len(req_len),
    .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready), .i_wdata(wdata),
    .o_rdata_valid(rdata_valid), .i_rdata_ready(rdata_ready), .o_rdata(rdata),
    .o_rdata_cnt(rdata_cnt), .o_rdata_last(rdata_last), .o_done(done),
    .o_mem_addr_w(mem_addr_w), .o_mem_data_w(mem_data_w), .o_mem_wr_size(mem_wr_size),
    .o_mem_wr_en(mem_wr_en), .o_mem_addr_r(mem_addr_r), .i_mem_data(mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory honours wr_size; unwritten words hold 0xC00000xx
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hC000_0000 | 32'(i);
    end else if (mem_wr_en) begin
      for (int k = 0; k < 5; k++)
        if (k < int'(mem_wr_size)) mem[8'(mem_addr_w + 24'(k))] <= mem_data_w[(5-k)*32-1 -: 32];
    end
  end

  always_comb begin
    for (int k = 0; k < 5; k++) mem_data[(5-k)*32-1 -: 32] = mem[8'(mem_addr_r + 24'(k))];
  end

  function automatic logic [159:0] pack5(input logic [31:0] a, b, c, d, e);
    return {a, b, c, d, e};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 7; i++) wd[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 5; i++) xd[i] = 32'h5000_0000 + 32'(i);
    junk = 32'hDEAD_BEEF;
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 0; req_we = 0; req_addr = '0; req_len = '0;
    wdata_valid = 0; wdata = '0; rdata_ready = 0;
    step; step;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    rst = 1'b0; mem_init = 1'b0;
    step;
    chk("post_rst_wr_en", mem_wr_en, 0);

    // write burst 0x10 len 7 with a one-cycle gap between beats
    req_valid = 1; req_we = 1; req_addr = 24'h10; req_len = 16'd7;
    chk("wr_req_ready", req_ready, 1);
    step; req_valid = 0;
    chk("wr_req_ready_low", req_ready, 0);
    chk("wr_wdata_ready", wdata_ready, 1);
    wdata_valid = 1; wdata = pack5(wd[0], wd[1], wd[2], wd[3], wd[4]);
    step; wdata_valid = 0;
    chk("wr1_en", mem_wr_en, 1);
    chk("wr1_addr", mem_addr_w, 24'h10);
    chk("wr1_size", mem_wr_size, 5);
    chk("wr1_data", mem_data_w, pack5(wd[0], wd[1], wd[2], wd[3], wd[4]));
    chk("wr1_done", done, 0);
    step;
    chk("wr_gap_en", mem_wr_en, 0);
    chk("wr_gap_wready", wdata_ready, 1);
    wdata_valid = 1; wdata = pack5(wd[5], wd[6], junk, junk, junk);
    step; wdata_valid = 0;
    chk("wr2_en", mem_wr_en, 1);
    chk("wr2_addr", mem_addr_w, 24'h15);
    chk("wr2_size", mem_wr_size, 2);
    chk("wr2_data", mem_data_w, pack5(wd[5], wd[6], junk, junk, junk));
    chk("wr2_done", done, 1);
    chk("wr2_wready", wdata_ready, 0);
    step;
    chk("wr_end_done", done, 0);
    chk("wr_end_en", mem_wr_en, 0);
    chk("wr_end_ready", req_ready, 1);

    // read back 7 words, ready held high
    req_valid = 1; req_we = 0; req_addr = 24'h10; req_len = 16'd7; rdata_ready = 1;
    step; req_valid = 0;
    chk("rd_t1_valid", rdata_valid, 0);
    chk("rd_t1_addr", mem_addr_r, 24'h10);
    step;
    chk("rd_b1_valid", rdata_valid, 1);
    chk("rd_b1_cnt", rdata_cnt, 5);
    chk("rd_b1_last", rdata_last, 0);
    chk("rd_b1_data", rdata, pack5(wd[0], wd[1], wd[2], wd[3], wd[4]));
    step;
    chk("rd_b2_valid", rdata_valid, 1);
    chk("rd_b2_cnt", rdata_cnt, 2);
    chk("rd_b2_last", rdata_last, 1);
    chk("rd_b2_data", rdata, pack5(wd[5], wd[6], 0, 0, 0));
    chk("rd_b2_done", done, 0);
    step;
    chk("rd_done", done, 1);
    chk("rd_done_valid", rdata_valid, 0);
    step;
    chk("rd_end_done", done, 0);
    chk("rd_end_ready", req_ready, 1);

    // backpressure read of 12 words, ready alternating
    req_valid = 1; req_we = 0; req_addr = 24'h10; req_len = 16'd12; rdata_ready = 0;
    step; req_valid = 0;
    chk("bp_t1_valid", rdata_valid, 0);
    step;
    chk("bp_b1_valid", rdata_valid, 1);
    chk("bp_b1_cnt", rdata_cnt, 5);
    chk("bp_b1_data", rdata, pack5(wd[0], wd[1], wd[2], wd[3], wd[4]));
    step;
    chk("bp_b1_hold_valid", rdata_valid, 1);
    chk("bp_b1_hold_data", rdata, pack5(wd[0], wd[1], wd[2], wd[3], wd[4]));
    chk("bp_b1_hold_cnt", rdata_cnt, 5);
    rdata_ready = 1;
    step; rdata_ready = 0;
    chk("bp_b2_cnt", rdata_cnt, 5);
    chk("bp_b2_last", rdata_last, 0);
    chk("bp_b2_data", rdata, pack5(wd[5], wd[6], 32'hC000_0017, 32'hC000_0018, 32'hC000_0019));
    step;
    chk("bp_b2_hold_data", rdata, pack5(wd[5], wd[6], 32'hC000_0017, 32'hC000_0018, 32'hC000_0019));
    chk("bp_b2_hold_valid", rdata_valid, 1);
    rdata_ready = 1;
    step; rdata_ready = 0;
    chk("bp_b3_cnt", rdata_cnt, 2);
    chk("bp_b3_last", rdata_last, 1);
    chk("bp_b3_data", rdata, pack5(32'hC000_001A, 32'hC000_001B, 0, 0, 0));
    step;
    chk("bp_b3_hold_valid", rdata_valid, 1);
    chk("bp_b3_hold_last", rdata_last, 1);
    chk("bp_b3_hold_done", done, 0);
    rdata_ready = 1;
    step;
    chk("bp_done", done, 1);
    chk("bp_done_valid", rdata_valid, 0);
    step;
    chk("bp_end_ready", req_ready, 1);

    // zero-length read then write
    req_valid = 1; req_we = 0; req_addr = 24'h40; req_len = 16'd0;
    step; req_valid = 0;
    chk("z0_done", done, 1);
    chk("z0_rvalid", rdata_valid, 0);
    chk("z0_wready", wdata_ready, 0);
    chk("z0_wr_en", mem_wr_en, 0);
    chk("z0_addr_r", mem_addr_r, 24'h1C);
    step;
    chk("z0_ready", req_ready, 1);
    chk("z0_done_end", done, 0);
    req_valid = 1; req_we = 1; req_addr = 24'h50; req_len = 16'd0;
    step; req_valid = 0;
    chk("z1_done", done, 1);
    chk("z1_wready", wdata_ready, 0);
    chk("z1_wr_en", mem_wr_en, 0);
    chk("z1_addr_w", mem_addr_w, 24'h15);
    step;
    chk("z1_ready", req_ready, 1);
    chk("z1_wr_en_end", mem_wr_en, 0);

    // address wrap on write and read-back
    req_valid = 1; req_we = 1; req_addr = 24'hFFFFFE; req_len = 16'd5;
    step; req_valid = 0;
    wdata_valid = 1; wdata = pack5(xd[0], xd[1], xd[2], xd[3], xd[4]);
    step; wdata_valid = 0;
    chk("wrap_wr_en", mem_wr_en, 1);
    chk("wrap_wr_addr", mem_addr_w, 24'hFFFFFE);
    chk("wrap_wr_size", mem_wr_size, 5);
    chk("wrap_wr_done", done, 1);
    step;
    chk("wrap_wr_ready", req_ready, 1);
    req_valid = 1; req_we = 0; req_addr = 24'hFFFFFE; req_len = 16'd5; rdata_ready = 1;
    step; req_valid = 0;
    chk("wrap_rd_addr", mem_addr_r, 24'hFFFFFE);
    step;
    chk("wrap_rd_cnt", rdata_cnt, 5);
    chk("wrap_rd_last", rdata_last, 1);
    chk("wrap_rd_data", rdata, pack5(xd[0], xd[1], xd[2], xd[3], xd[4]));
    step;
    chk("wrap_rd_done", done, 1);
    chk("wrap_rd_ptr", mem_addr_r, 24'h000003);
    step;

    // reset during a read after the first beat
    req_valid = 1; req_we = 0; req_addr = 24'h10; req_len = 16'd12; rdata_ready = 0;
    step; req_valid = 0;
    step;
    chk("mid_b1_valid", rdata_valid, 1);
    rst = 1;
    step; rst = 0;
    chk("mid_rst_valid", rdata_valid, 0);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_wr_en", mem_wr_en, 0);
    req_valid = 1; req_we = 0; req_addr = 24'h10; req_len = 16'd7; rdata_ready = 1;
    step; req_valid = 0;
    chk("fresh_t1_valid", rdata_valid, 0);
    step;
    chk("fresh_b1_cnt", rdata_cnt, 5);
    chk("fresh_b1_data", rdata, pack5(wd[0], wd[1], wd[2], wd[3], wd[4]));
    step;
    chk("fresh_b2_last", rdata_last, 1);
    chk("fresh_b2_data", rdata, pack5(wd[5], wd[6], 0, 0, 0));
    step;
    chk("fresh_done", done, 1);
    step;
    chk("fresh_end_ready", req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
